// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED bounce sequencer.
// Imported by led_seq_ctrl and led_seq_prescaler.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2
    } state_t;

    localparam logic [2:0] POS_MIN  = 3'd0;
    localparam logic [2:0] POS_MAX  = 3'd7;
    localparam int         NUM_LEDS = 8;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [2:0] p);
        onehot    = '0;
        onehot[p] = 1'b1;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts 0..div-1 while enabled and strobes at the end.
// Counter returns to zero whenever disabled or cleared.
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term = (cnt == div - CNT_W'(1));
    assign tick = en && !clr && term;

    // Count cycles; wrap at terminal, hold at zero while idle or cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bounce controller: run/pause/single-step over a selectable step rate.
// Define LED_SEQ_TRAIL_EN for a two-LED comet (current + previous position).
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DIV0  = 50_000_000,
    parameter int DIV1  = 25_000_000,
    parameter int DIV2  = 12_500_000,
    parameter int DIV3  = 6_250_000,
    parameter int CNT_W = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic [1:0]          speed,
    output logic [NUM_LEDS-1:0] lights,
    output logic [2:0]          pos,
    output logic                dir,
    output logic                tick
);

    state_t             state;
    state_t             state_n;
    logic [2:0]         pos_n;
    logic               dir_n;
    logic               adv;
    logic               armed;
    logic [1:0]         speed_q;
    logic [CNT_W-1:0]   div;
    logic               pre_en;
    logic               pre_clr;
    logic               pre_tick;
    logic [NUM_LEDS-1:0] lights_n;
`ifdef LED_SEQ_TRAIL_EN
    logic [2:0]         prev_pos;
    logic [2:0]         prev_pos_n;
`endif

    // Select the step period for the current speed setting.
    always_comb begin
        div = CNT_W'(DIV0);
        unique case (speed)
            2'd0: div = CNT_W'(DIV0);
            2'd1: div = CNT_W'(DIV1);
            2'd2: div = CNT_W'(DIV2);
            2'd3: div = CNT_W'(DIV3);
            default: div = CNT_W'(DIV0);
        endcase
    end

    assign pre_en  = (state != S_PAUSE) && run;
    assign pre_clr = (speed != speed_q);

    led_seq_prescaler #(
        .CNT_W (CNT_W)
    ) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .div   (div),
        .tick  (pre_tick)
    );

    // Next state, position, direction and turn-around at the end stops.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        dir_n   = dir;
        adv     = 1'b0;
        unique case (state)
            S_PAUSE: begin
                if (armed && run) begin
                    state_n = dir ? S_UP : S_DOWN;
                end else if (armed && step) begin
                    adv = 1'b1;
                end
            end
            S_UP, S_DOWN: begin
                if (!run) begin
                    state_n = S_PAUSE;
                end else if (pre_tick) begin
                    adv = 1'b1;
                end
            end
            default: state_n = S_PAUSE;
        endcase
        if (adv) begin
            if (dir) begin
                pos_n = pos + 3'd1;
                if (pos_n == POS_MAX) begin
                    dir_n = 1'b0;
                    if (state != S_PAUSE) state_n = S_DOWN;
                end
            end else begin
                pos_n = pos - 3'd1;
                if (pos_n == POS_MIN) begin
                    dir_n = 1'b1;
                    if (state != S_PAUSE) state_n = S_UP;
                end
            end
        end
    end

`ifdef LED_SEQ_TRAIL_EN
    // Comet display: current position plus the one just left.
    always_comb begin
        prev_pos_n = adv ? pos : prev_pos;
        lights_n   = onehot(pos_n) | onehot(prev_pos_n);
    end
`else
    // Single lit LED at the current position.
    always_comb begin
        lights_n = onehot(pos_n);
    end
`endif

    // State and registered outputs; armed delays run by one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_PAUSE;
            pos     <= POS_MIN;
            dir     <= 1'b1;
            tick    <= 1'b0;
            armed   <= 1'b0;
            speed_q <= 2'd0;
            lights  <= onehot(POS_MIN);
`ifdef LED_SEQ_TRAIL_EN
            prev_pos <= POS_MIN;
`endif
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            dir     <= dir_n;
            tick    <= adv;
            armed   <= 1'b1;
            speed_q <= speed;
            lights  <= lights_n;
`ifdef LED_SEQ_TRAIL_EN
            prev_pos <= prev_pos_n;
`endif
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with short step periods (4,3,2,1).
// Phase-based reference model plus vector table and directed sequences.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [1:0] speed;
    logic [7:0] lights;
    logic [2:0] pos;
    logic       dir;
    logic       tick;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .DIV0  (4),
        .DIV1  (3),
        .DIV2  (2),
        .DIV3  (1),
        .CNT_W (26)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .step   (step),
        .speed  (speed),
        .lights (lights),
        .pos    (pos),
        .dir    (dir),
        .tick   (tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the bounce is a 14-phase cycle; k is the phase.
    int       divs [4] = '{4, 3, 2, 1};
    int       k;
    int       prv;
    int       cnt;
    bit       running;
    bit       armed;
    bit [1:0] last_spd;
    bit       m_tick;

    function automatic int kpos(input int kk);
        return (kk < 8) ? kk : 14 - kk;
    endfunction

    function automatic bit kdir(input int kk);
        return (kk < 7);
    endfunction

    task automatic m_reset();
        k = 0; prv = 0; cnt = 0;
        running = 0; armed = 0;
        last_spd = 0; m_tick = 0;
    endtask

    task automatic m_adv();
        prv = kpos(k);
        k = (k + 1) % 14;
        m_tick = 1;
    endtask

    task automatic m_edge(input bit r, input bit s, input bit [1:0] sp);
        m_tick = 0;
        if (!running) begin
            if (armed && r) begin
                running = 1;
                cnt = 0;
            end else if (armed && s) begin
                m_adv();
            end
        end else begin
            if (!r) begin
                running = 0;
                cnt = 0;
            end else if (sp != last_spd) begin
                cnt = 0;
            end else if (cnt == divs[sp] - 1) begin
                m_adv();
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        last_spd = sp;
        armed = 1;
    endtask

    function automatic logic [7:0] m_lights();
        logic [7:0] l;
        l = 8'h01 << kpos(k);
`ifdef LED_SEQ_TRAIL_EN
        l = l | (8'h01 << prv);
`endif
        return l;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pos"}, pos, kpos(k));
        chk({tag, "_dir"}, dir, kdir(k));
        chk({tag, "_tick"}, tick, m_tick);
        chk({tag, "_lights"}, lights, m_lights());
    endtask

    // One clock: drive inputs away from the edge, advance model, check.
    task automatic cyc(input bit r, input bit s, input bit [1:0] sp);
        run = r; step = s; speed = sp;
        @(posedge clk);
        m_edge(r, s, sp);
        #1;
        chk_model("model");
    endtask

    // Asynchronous reset in the middle of the high phase.
    task automatic do_reset(input bit r);
        #2;
        rst_n = 1'b0;
        run = r; step = 1'b0; speed = 2'd0;
        #1;
        m_reset();
        chk("rst_lights", lights, 8'h01);
        chk("rst_pos", pos, 0);
        chk("rst_dir", dir, 1);
        chk("rst_tick", tick, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         run;
        bit         step;
        bit [1:0]   speed;
        bit [2:0]   pos;
        bit         dir;
        bit         tick;
        logic [7:0] lights;
    } vec_t;

    vec_t tbl [19];

    initial begin
        bit [2:0]   sp_pos  [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5};
        logic [7:0] trail_l [9] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0, 8'h60};
        int walk [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        int n;
        bit cur_run;
        bit [1:0] cur_spd;

        // Paused single-step vectors: arm edge, then step/idle pairs.
        tbl[0] = '{0, 0, 2'd0, 3'd0, 1, 0, 8'h01};
        for (int i = 0; i < 9; i++) begin
            logic [7:0] lt;
`ifdef LED_SEQ_TRAIL_EN
            lt = trail_l[i];
`else
            lt = 8'h01 << sp_pos[i];
`endif
            tbl[1 + 2 * i] = '{0, 1, 2'd0, sp_pos[i], (i < 6), 1, lt};
            tbl[2 + 2 * i] = '{0, 0, 2'd0, sp_pos[i], (i < 6), 0, lt};
        end

        rst_n = 1'b0; run = 1'b0; step = 1'b0; speed = 2'd0;
        m_reset();
        #12;

        do_reset(0);
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].run, tbl[i].step, tbl[i].speed);
            chk("tbl_pos", pos, tbl[i].pos);
            chk("tbl_dir", dir, tbl[i].dir);
            chk("tbl_tick", tick, tbl[i].tick);
            chk("tbl_lights", lights, tbl[i].lights);
        end

        // Run at speed 0: first tick 4 cycles after entering, then full walk.
        do_reset(0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        n = 0;
        do begin cyc(1, 0, 0); n++; end while (!tick && n < 10);
        chk("first_tick_lat", n, 4);
        chk("walk_pos0", pos, walk[0]);
        for (int i = 1; i < 15; i++) begin
            n = 0;
            do begin cyc(1, 0, 0); n++; end while (!tick && n < 10);
            chk("walk_tick", tick, 1);
            chk("walk_pos", pos, walk[i]);
            if (i == 6) chk("walk_dir_top", dir, 0);
            if (i == 13) chk("walk_dir_bot", dir, 1);
        end

        // Pause at pos 3 moving down, hold, then resume.
        do_reset(0);
        cyc(0, 0, 3);
        cyc(1, 0, 3);
        n = 0;
        do begin cyc(1, 0, 3); n++; end while (!(pos == 3 && dir == 0) && n < 40);
        chk("pause_reach3", pos, 3);
        for (int i = 0; i < 20; i++) cyc(0, 0, 3);
        chk("pause_hold_pos", pos, 3);
        chk("pause_hold_tick", tick, 0);
        cyc(1, 0, 3);
        chk("resume_enter_tick", tick, 0);
        cyc(1, 0, 3);
        chk("resume_pos", pos, 2);
        chk("resume_dir", dir, 0);
        chk("resume_tick", tick, 1);

        // Speed change on the terminal count suppresses that advance.
        do_reset(0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        chk("spd_pre_tick", tick, 0);
        cyc(1, 0, 3);
        chk("spd_chg_tick", tick, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 3);
            chk("spd_fast_tick", tick, 1);
        end

        // Reset mid-sweep at pos 5, release with run held high.
        n = 0;
        do begin cyc(1, 0, 3); n++; end while (pos != 5 && n < 40);
        chk("rst_reach5", pos, 5);
        do_reset(1);
        cyc(1, 0, 0);
        chk("rst_arm_tick", tick, 0);
        chk("rst_arm_pos", pos, 0);
        cyc(1, 0, 3);
        chk("rst_enter_tick", tick, 0);
        cyc(1, 0, 3);
        chk("rst_run_tick", tick, 1);
        chk("rst_run_pos", pos, 1);

        // Randomized traffic against the phase model.
        cur_run = 0;
        cur_spd = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset(1'($urandom_range(1)));
            end else begin
                if ($urandom_range(9) == 0) cur_run = ~cur_run;
                if ($urandom_range(19) == 0) cur_spd = 2'($urandom_range(3));
                cyc(cur_run, ($urandom_range(3) == 0), cur_spd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Controller for the LED bounce display. It runs on the fast system clock and divides it internally into a selectable step rate; no derived clock is used. It sequences a single lit LED back and forth across `lights[7:0]`, and supports pause, resume and manual single-step. It sits between the board pushbuttons/switches (already synchronised and debounced upstream) and the LEDR outputs.

## Interface
Parameters:
- `DIV0`, default 50_000_000: step period in clk cycles for `speed`=0 (1 Hz at 50 MHz).
- `DIV1`, default 25_000_000: step period for `speed`=1.
- `DIV2`, default 12_500_000: step period for `speed`=2.
- `DIV3`, default 6_250_000: step period for `speed`=3.
- `CNT_W`, default 26: prescaler counter width; must hold `DIVn`-1 for every n.

Ports:
- `clk`  in  1  system clock. One clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run`  in  1  level. 1 = auto-advance, 0 = paused.
- `step`  in  1  single-cycle pulse. Advances one position while paused.
- `speed`  in  2  step-rate select, indexes `DIV0`..`DIV3`.
- `lights`  out  8  LED drive.
- `pos`  out  3  current lit position.
- `dir`  out  1  1 = moving up (toward bit 7), 0 = moving down.
- `tick`  out  1  one-cycle strobe, high in the cycle that `pos` is updated.

## Operation
- The FSM has three states: `S_PAUSE`, `S_UP`, `S_DOWN`. The `dir` register persists across pause.
- Reset values: state `S_PAUSE`, `pos`=0, `dir`=1, `lights`=8'h01, `tick`=0, prescaler=0.
- `S_PAUSE`:
  - `run`=1 → `S_UP` if `dir`=1, else `S_DOWN`. The prescaler restarts at 0.
  - `step`=1 and `run`=0 → one advance in direction `dir`. The state stays `S_PAUSE`.
- `S_UP`/`S_DOWN`:
  - The prescaler counts 0..DIVsel-1. At DIVsel-1 it performs one advance and wraps to 0.
  - `run`=0 → `S_PAUSE`. The prescaler clears and no advance occurs that cycle.
- Advance rules:
  - Up: `pos`←`pos`+1. If the new `pos`=7, then `dir`←0 and state→`S_DOWN` (stays `S_PAUSE` if paused).
  - Down: `pos`←`pos`-1. If the new `pos`=0, then `dir`←1 and state→`S_UP`.
  - The end positions are therefore shown once per sweep. The full period is 14 advances: 0,1..7,6..1,0.
- `lights` = 1<<`pos` (see Configuration). It is a registered output and never shows zero or multiple bits in base mode.
- `pos` arithmetic is 3-bit unsigned. Underflow and overflow are unreachable by construction; the turn logic prevents them.

## Timing
- `tick` and the `pos`/`lights` update occur in the same clock. Outputs are valid the cycle after the advancing edge.
- In run mode, the first advance comes DIVsel cycles after entering `S_UP`/`S_DOWN`.
- Step latency: `step` sampled high at edge N → new `pos` visible after edge N.
- `step` while in `S_UP`/`S_DOWN` is ignored. If `run` and `step` are both high in `S_PAUSE`, `run` wins and `step` is dropped.
- A `speed` change in any state clears the prescaler to 0 on the next edge. No advance occurs in that cycle, even if the old count was terminal.
- `rst_n` low at any time (including mid-count or mid-sweep) forces all reset values immediately. On the first edge after `rst_n` rises, state is `S_PAUSE` regardless of `run`. `run` is acted on from the following edge.

## Configuration
- `LED_SEQ_TRAIL_EN` defined: a `prev_pos` register is captured on every advance (reset 0). The output is `lights` = (1<<`pos`) | (1<<`prev_pos`), giving a two-LED comet. At reset only bit 0 is lit.
- Not defined: no `prev_pos` register, and single-LED output exactly as in Operation.

## Structure
- Package `led_seq_pkg` holds:
  - the `state_t` enum (`S_PAUSE`, `S_UP`, `S_DOWN`);
  - the constants `POS_MIN`=0, `POS_MAX`=7, `NUM_LEDS`=8.
- Sub-module `led_seq_prescaler`:
  - Inputs: `clk`, `rst_n`, `en`, `clr`, `div`.
  - Output: `tick`.
  - Divisor selection and the FSM/position logic stay in `led_seq_ctrl`.

## Test plan
Run all scenarios with DIV0..DIV3 overridden to 4, 3, 2, 1.
- Reset, then `run`=1, `speed`=0 → the first `tick` arrives 4 cycles after entering `S_UP`. `pos` walks 1..7,6..0,1, with `dir` flipping exactly at 7 and 0.
- Paused, apply `step` ×9 → `pos` sequence 1..7,6,5; `dir`=0 after the 7th step. No ticks occur between steps.
- Drop `run` at `pos`=3 going down, wait 20 cycles, raise `run` → `pos` holds at 3, then resumes at 2 with `dir`=0.
- Change `speed` 0→3 when the prescaler is at 3 → no tick that cycle. After that, one tick every cycle.
- Assert `rst_n`=0 mid-sweep at `pos`=5 → outputs are immediately 8'h01, `pos`=0, `dir`=1. Raising `rst_n` with `run`=1 gives one edge in `S_PAUSE` before running.
- With `LED_SEQ_TRAIL_EN`: advances 0→1→2 give `lights` = 8'h01, 8'h03, 8'h06; the turn at 7 gives 8'hC0 then 8'hC0 (pos 6, prev 7).
